// File: rtl/pwm_capture.sv
// PWM receiver: measures period/high time of pwm_in in clk cycles, flags a stuck input.
// Latency: meas_valid 3 clk after the closing rising edge reaches pwm_in; no backpressure (strobe-only output).
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Everything keys off s2, so the synchronizer delay cancels out of both measurements.
    assign rise = s2 & ~s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            period_cnt  <= '0;
            high_cnt    <= '0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    period_cnt <= '0;
                    high_cnt   <= '0;
                    if (rise) begin
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                        stuck      <= 1'b0;
                        state      <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise on the timeout cycle still closes a valid period.
                    if (rise) begin
                        period     <= period_cnt;
                        high_time  <= high_cnt;
                        meas_valid <= 1'b1;
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                    end else if (period_cnt == TO_VAL) begin
                        stuck       <= 1'b1;
                        stuck_level <= s2;
                        period_cnt  <= '0;
                        high_cnt    <= '0;
                        state       <= IDLE;
                    end else begin
                        if (period_cnt != CNT_MAX)
                            period_cnt <= period_cnt + CNT_ONE;
                        if (s2 && (high_cnt != CNT_MAX))
                            high_cnt <= high_cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- PWM receiver: measures the period and high time of an external PWM waveform (e.g. the LED glow output) in `clk` cycles.
- Reports one measurement per complete period, qualified by a single-cycle valid strobe.
- Flags a stuck (DC) input.
- Sits on the input side of the PWM path: a loopback checker for the LED PWM generator, or a decoder for PWM-encoded sensor and servo inputs.

Parameters:
- CNT_W, 16, width of the period and high-time counters and outputs.
- TIMEOUT, 65535, cycles without a rising edge before `stuck` asserts. Must be ≤ 2^CNT_W − 1 and ≥ 4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pwm_in  input  1  asynchronous PWM waveform.
- period  output  CNT_W  last measured period in clk cycles.
- high_time  output  CNT_W  last measured high time in clk cycles.
- meas_valid  output  1  one-cycle strobe when `period`/`high_time` update.
- stuck  output  1  high while no rising edge has been seen for TIMEOUT cycles.
- stuck_level  output  1  synchronized `pwm_in` level captured when `stuck` asserted.

Behaviour:
- Reset: one clock; `rst` is asynchronous and active-high. All flops clear to 0, including synchronizer stages, counters, `period`, `high_time`, `meas_valid`, `stuck` and `stuck_level`. FSM goes to IDLE.
- Input conditioning:
  - Two-flop synchronizer s1 → s2, plus delay flop s3.
  - rise = s2 & ~s3.
  - All measurement uses s2, so the fixed 2-cycle synchronizer latency cancels out of period and high time.
  - Glitches shorter than one clk period may be missed; no filtering is done.
- FSM states:
  - IDLE: no reference edge yet. Counters are held at 0. On rise: period_cnt <= 1, high_cnt <= 1, go to MEASURE. No `meas_valid`.
  - MEASURE, cycle without rise:
    - period_cnt += 1.
    - high_cnt += s2.
    - Both saturate at 2^CNT_W − 1.
  - MEASURE, cycle with rise:
    - period <= period_cnt, high_time <= high_cnt, meas_valid <= 1 (output registered, visible the next cycle).
    - period_cnt <= 1, high_cnt <= 1.
    - Stay in MEASURE.
  - MEASURE, timeout: if period_cnt == TIMEOUT and no rise this cycle:
    - stuck <= 1, stuck_level <= s2.
    - Go to IDLE, counters to 0.
    - `period`/`high_time` keep their last values; no strobe.
  - IDLE while stuck: `stuck` stays 1 until the next rise. On that rise: stuck <= 0 in the same cycle, re-arm into MEASURE. The first period after recovery is not reported.
- Timing guarantees:
  - The rise cycle counts as cycle 1 of the new period.
  - For a stable waveform with period P and high time H (in clk cycles), the reported values are exactly P and H.
  - First `meas_valid` occurs on the second rising edge after reset, 3 clk after that edge reaches `pwm_in` (2 sync + 1 output register).
- Boundary cases:
  - Duty 0% or 100% (no edges): after TIMEOUT cycles in MEASURE, `stuck` = 1 and `stuck_level` = 0 or 1 respectively.
  - Minimum measurable period: 2 cycles (P = 2, H = 1).
  - `meas_valid` is never high on two consecutive cycles.
  - Rise and timeout in the same cycle: rise wins. Report normally; `stuck` is not set.
  - Saturation: reachable only if TIMEOUT = 2^CNT_W − 1. Counters hold at max and never wrap.
  - `rst` asserted mid-period: immediate clear. After release, the first partial period is discarded (IDLE).

Test Plan:
- Reset then 10 steady periods of P = 100, H = 25 → first `meas_valid` after 2nd edge; every strobe shows period = 100, high_time = 25; strobes exactly 100 cycles apart.
- Change duty on the fly from H = 25 to H = 75 at P = 100 → the transition period reports the actual cycles; subsequent reports are 100/75; no missed or double strobes.
- Minimum waveform P = 2, H = 1 (toggle every clk) → reports 2/1 on every strobe; `meas_valid` pulses every other cycle.
- TIMEOUT = 50, hold `pwm_in` = 1 after a valid period → `stuck` = 1 and `stuck_level` = 1 exactly 50 cycles after the last rise; `period`/`high_time` unchanged. Next rise → `stuck` = 0, no strobe; the following rise reports correctly.
- Same with `pwm_in` held at 0 → `stuck_level` = 0.
- Assert `rst` for 3 cycles mid-period at P = 100 → all outputs 0 immediately (asynchronously). First strobe after release comes on the 2nd rise, reporting 100/25.
